dst7_16_seq_ctrl: RTL and testbench
===================================

// Module: dst7_16_seq_ctrl
// PURPOSE
//  Sequencing controller for the 16-point DST-VII 1-D forward transform built on sau_16.
//  Accepts 16 residual samples serially (one per handshake), drives each into sau_16, and
//  sign-selects and accumulates the 16 products into 16 row accumulators.
//  After the 16th sample it rounds, shifts and clamps the row sums, then presents all 16
//  coefficients in parallel. It sits between the residual buffer and the transpose memory.
// PARAMETERS
//  IN_W    16  signed input sample width; legal range 8..20
//  ACC_W   32  accumulator width; matches the sau_16 output width
//  OUT_W   16  signed output coefficient width
// PORTS
//  clk        in   1         clock
//  rst_n      in   1         synchronous reset, active low
//  cfg_shift  in   5         right-shift amount; latched when sample 0 is accepted
//  in_valid   in   1         a sample is offered
//  in_ready   out  1         the controller accepts a sample
//  in_data    in   IN_W      signed sample x[n]; n = 0..15 in order
//  out_valid  out  1         coefficient block valid
//  out_ready  in   1         consumer accepts the block
//  out_data   out  16*OUT_W  Y[k] occupies bits [k*OUT_W +: OUT_W]; k = 0..15
// BEHAVIOUR
//  - Reset: state=IDLE, sample counter n=0, accumulators=0, out_valid=0, out_data=0, in_ready=0.
//    A reset asserted mid-block aborts the block. No partial result is ever emitted.
//  - FSM states:
//    IDLE: in_ready=1. On accept: acc[k] <= p[k] (load, not add), latch cfg_shift, n <= 1, go to ACCUM.
//    ACCUM: in_ready=1. On accept: acc[k] <= acc[k] + p[k], n <= n+1. Accept at n==15 -> ROUND.
//      Cycles without in_valid hold all state.
//    ROUND: in_ready=0. One cycle. r[k] = (acc[k] + (shift ? 1<<(shift-1) : 0)) >>> shift,
//      then clamp/truncate to OUT_W into out_data. Next state OUTPUT.
//    OUTPUT: in_ready=0, out_valid=1, out_data stable. On out_ready go to IDLE.
//      in_ready rises in the following cycle.
//  - Product path: in_data is sign-extended to 32 bits and feeds sau_16 combinationally in the
//    accept cycle. p[k] = COEF_NEG[k][n] ? -Y_sau[COEF_IDX[k][n]] : +Y_sau[COEF_IDX[k][n]].
//  - Latency: 2 cycles from acceptance of the 16th sample to out_valid.
//    Minimum block period is 19 cycles.
//  - Arithmetic: two's complement throughout. |acc| <= 45*2^(IN_W-1)*16 < 2^31, so no
//    accumulator overflow is possible for legal IN_W.
//  - in_valid/in_data are don't-care while in_ready=0. out_valid drops only after a handshake.
// CONFIGURATION
//  DST7_SEQ_SAT_EN defined: the ROUND stage saturates each r[k] to
//    [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  DST7_SEQ_SAT_EN undefined: the ROUND stage keeps the low OUT_W bits of r[k] (wraps).
//    No compare logic is built.
// STRUCTURE
//  - Package dst7_pkg holds:
//    - the state enum (IDLE, ACCUM, ROUND, OUTPUT);
//    - the N=16 constant;
//    - the COEF_IDX[16][16] 4-bit magnitude-index table;
//    - the COEF_NEG[16][16] sign table;
//    - the magnitude list 4,8,13,17,20,24,28,31,34,36,39,41,42,43,44,45.
//    The tables are generated by the team coefficient script; the golden model uses the same tables.
//  - One sau_16 instance, plus sub-module dst7_acc_lane (x16). Each lane does the
//    sign-select, load/add, round and clamp for one row k.
//  - Column n=0 of COEF_IDX is k, and all of column 0 is positive.
// TESTING
//  1. Impulse x[0]=1, x[1..15]=0, shift=0 -> Y[0..15] = 4,8,13,17,20,24,28,31,34,36,39,41,42,43,44,45.
//  2. Impulse x[0]=1000, shift=3 -> Y[0]=500 ((4000+4)>>3), Y[15]=5625; x[0]=-1, shift=0 -> Y[0]=-4, Y[15]=-45.
//  3. Impulse x[0]=32767, shift=0, OUT_W=16:
//     with SAT_EN -> Y[0]=Y[15]=32767; without -> Y[0]=-4, Y[15]=32723.
//  4. Random block with in_valid gaps plus out_ready held low 5 cycles:
//     - out_data is stable while held and in_ready stays 0;
//     - the result equals the gapless run and the golden model.
//  5. rst_n low after 7 accepted samples, then a full impulse block -> exactly the case-1 result;
//     out_valid stays 0 until then.
//  6. Back-to-back blocks, in_valid and out_ready constantly high -> one block every 19 cycles;
//     each result matches the golden model; shift is re-latched per block.

Source files
------------

// File: rtl/dst7_pkg.sv
// dst7_pkg: state encoding, magnitude list and coefficient index/sign tables for the DST-VII sequencer.
// Latency: none (types and constants only).
// Backpressure: n/a. Build option DST7_SEQ_SAT_EN (saturating vs wrapping output) is applied in the lanes.
package dst7_pkg;

  localparam int N = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ROUND  = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  // Coefficient magnitudes, indexed by COEF_IDX.
  localparam int MAG [N] = '{4, 8, 13, 17, 20, 24, 28, 31, 34, 36, 39, 41, 42, 43, 44, 45};

  typedef logic [N-1:0][N-1:0][3:0] idx_tbl_t;
  typedef logic [N-1:0][N-1:0]      neg_tbl_t;

  // Row k, sample n: angle index (k+1)(2n+1) folded onto the quarter wave gives the magnitude slot.
  function automatic idx_tbl_t gen_coef_idx();
    idx_tbl_t tbl;
    int m;
    int r;
    for (int k = 0; k < N; k++) begin
      for (int n = 0; n < N; n++) begin
        m = ((k + 1) * (2 * n + 1)) % 64;
        r = m % 32;
        if (r > 16) r = 32 - r;
        tbl[k][n] = 4'(r - 1);
      end
    end
    return tbl;
  endfunction

  // The second half of the angle period carries a negative sign.
  function automatic neg_tbl_t gen_coef_neg();
    neg_tbl_t tbl;
    int m;
    for (int k = 0; k < N; k++) begin
      for (int n = 0; n < N; n++) begin
        m = ((k + 1) * (2 * n + 1)) % 64;
        tbl[k][n] = (m > 32);
      end
    end
    return tbl;
  endfunction

  localparam idx_tbl_t COEF_IDX = gen_coef_idx();
  localparam neg_tbl_t COEF_NEG = gen_coef_neg();

endpackage

// File: rtl/dst7_acc_lane.sv
// dst7_acc_lane: one output row k -- sign-select, load/accumulate, round-shift and clamp (DST7_SEQ_SAT_EN) or wrap.
// Latency: accumulator updates on the accept edge; coefficient registers on the round edge.
// Backpressure: none; the controller sequences load/add/round strobes.
module dst7_acc_lane
  import dst7_pkg::*;
#(
  parameter int K     = 0,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      add,
  input  logic                      round,
  input  logic [3:0]                n,
  input  logic [4:0]                shift,
  input  logic [N-1:0][ACC_W-1:0]   y_sau,
  output logic [OUT_W-1:0]          coef
);

  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   biased;
  logic [OUT_W-1:0]        coef_q, coef_d;

`ifdef DST7_SEQ_SAT_EN
  localparam logic signed [ACC_W:0] SAT_HI = $signed((ACC_W+1)'(2 ** (OUT_W - 1) - 1));
  localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;
  logic signed [ACC_W:0] shifted;
`endif

  // Pick this row's multiple for sample n and apply its sign.
  always_comb begin
    prod = $signed(y_sau[COEF_IDX[K][n]]);
    if (COEF_NEG[K][n]) prod = -prod;
  end

  // Accumulate, then round-half-up, arithmetic shift and fit to OUT_W on the round strobe.
  always_comb begin
    acc_d = acc_q;
    if (load) acc_d = prod;
    else if (add) acc_d = acc_q + prod;
    rnd    = (shift == 5'd0) ? '0 : ((ACC_W+1)'(1) << (shift - 5'd1));
    biased = $signed({acc_q[ACC_W-1], acc_q}) + rnd;
    coef_d = coef_q;
`ifdef DST7_SEQ_SAT_EN
    shifted = biased >>> shift;
    if (round) begin
      if (shifted > SAT_HI)      coef_d = SAT_HI[OUT_W-1:0];
      else if (shifted < SAT_LO) coef_d = SAT_LO[OUT_W-1:0];
      else                       coef_d = shifted[OUT_W-1:0];
    end
`else
    if (round) coef_d = OUT_W'(biased >>> shift);
`endif
  end

  // Row state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      coef_q <= '0;
    end else begin
      acc_q  <= acc_d;
      coef_q <= coef_d;
    end
  end

  assign coef = coef_q;

endmodule

// File: rtl/sau_16.sv
// sau_16: produces the 16 constant multiples MAG[i]*x of one sample.
// Latency: combinational.
// Backpressure: none; purely combinational.
module sau_16
  import dst7_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic signed [ACC_W-1:0]      x,
  output logic [N-1:0][ACC_W-1:0]      y
);

  // Constant multiplies reduce to shift-add trees in synthesis.
  for (genvar i = 0; i < N; i++) begin : g_mul
    assign y[i] = x * $signed(ACC_W'(MAG[i]));
  end

endmodule

// File: rtl/dst7_16_seq_ctrl.sv
// dst7_16_seq_ctrl: serial 16-sample DST-VII forward row transform; output saturates under DST7_SEQ_SAT_EN, else wraps.
// Latency: out_valid 2 cycles after the 16th accepted sample; minimum block period 19 cycles.
// Backpressure: in_ready low from the last sample until one cycle after the output handshake; block held until out_ready.
module dst7_16_seq_ctrl
  import dst7_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           cfg_shift,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*OUT_W-1:0]   out_data
);

  state_e                   state_q, state_d;
  logic [3:0]               n_q, n_d;
  logic [4:0]               shift_q, shift_d;
  logic                     in_ready_q, in_ready_d;
  logic                     accept;
  logic                     acc_load, acc_add, do_round;
  logic signed [ACC_W-1:0]  x_ext;
  logic [N-1:0][ACC_W-1:0]  y_sau;

  assign accept = in_valid & in_ready_q;
  assign x_ext  = ACC_W'($signed(in_data));

  // Next state, sample counter, shift latch and lane strobes.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    shift_d    = shift_q;
    in_ready_d = 1'b0;
    acc_load   = 1'b0;
    acc_add    = 1'b0;
    do_round   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          acc_load = 1'b1;
          shift_d  = cfg_shift;
          n_d      = 4'd1;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        in_ready_d = 1'b1;
        if (accept) begin
          acc_add = 1'b1;
          n_d     = n_q + 4'd1;
          if (n_q == 4'(N - 1)) begin
            state_d    = ROUND;
            in_ready_d = 1'b0;
          end
        end
      end
      ROUND: begin
        do_round = 1'b1;
        state_d  = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers; a reset mid-block discards the partial block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      shift_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      shift_q    <= shift_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == OUTPUT);

  sau_16 #(.ACC_W(ACC_W)) u_sau (
    .x (x_ext),
    .y (y_sau)
  );

  for (genvar k = 0; k < N; k++) begin : g_lane
    dst7_acc_lane #(
      .K     (k),
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (acc_load),
      .add   (acc_add),
      .round (do_round),
      .n     (n_q),
      .shift (shift_q),
      .y_sau (y_sau),
      .coef  (out_data[k*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_dst7_16_seq_ctrl.sv
// tb_dst7_16_seq_ctrl: directed scenarios for the DST-VII sequencer with a bench-side golden model.
// Latency: checks out_valid 2 cycles after the last sample and a 19-cycle back-to-back period.
// Backpressure: holds out_ready low and inserts in_valid gaps.
module tb_dst7_16_seq_ctrl;
  import dst7_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   cfg_shift = 5'd0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_data = 16'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] out_data;

  int total = 0;
  int bad = 0;
  logic signed [15:0] got [16];
  int exp_y [16];
  int mx [16];
  localparam int CASE1 [16] = '{4, 8, 13, 17, 20, 24, 28, 31, 34, 36, 39, 41, 42, 43, 44, 45};

  dst7_16_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_shift (cfg_shift),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture();
    for (int k = 0; k < 16; k++) got[k] = out_data[k*16 +: 16];
  endtask

  // Golden model: direct multiply-accumulate, round-half-up, shift, then saturate or wrap.
  task automatic run_model(input int sh);
    for (int k = 0; k < 16; k++) begin
      longint acc;
      longint bias;
      longint r;
`ifndef DST7_SEQ_SAT_EN
      logic [15:0] lo;
`endif
      acc = 0;
      for (int n = 0; n < 16; n++) begin
        if (COEF_NEG[k][n]) acc = acc - MAG[COEF_IDX[k][n]] * mx[n];
        else                acc = acc + MAG[COEF_IDX[k][n]] * mx[n];
      end
      bias = (sh == 0) ? 0 : (longint'(1) <<< (sh - 1));
      r = (acc + bias) >>> sh;
`ifdef DST7_SEQ_SAT_EN
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      exp_y[k] = int'(r);
`else
      lo = r[15:0];
      exp_y[k] = int'($signed(lo));
`endif
    end
  endtask

  task automatic send(input int x, input bit keep);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = 16'(x);
    while (!in_ready && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) begin
      total++;
      bad++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    step();
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic run_block(input int sh, input bit gaps);
    cfg_shift = 5'(sh);
    for (int n = 0; n < 16; n++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        repeat ($urandom_range(0, 3)) step();
      end
      send(mx[n], 1'b0);
      if (n == 0) cfg_shift = 5'd31;
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL out_valid_timeout got=%b required=1", out_valid);
    end
    capture();
  endtask

  task automatic ack();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic impulse(input int x, input int sh);
    int lat;
    for (int n = 0; n < 16; n++) mx[n] = 0;
    mx[0] = x;
    run_block(sh, 1'b0);
    wait_out(lat);
    ack();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h1234;
    repeat (3) step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b required=0", in_ready); end
    total++;
    if (out_data !== 256'd0) begin bad++; $display("FAIL reset_out_data got=%h required=0", out_data); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_impulse_unit();
    int lat;
    for (int n = 0; n < 16; n++) mx[n] = 0;
    mx[0] = 1;
    run_block(0, 1'b0);
    wait_out(lat);
    total++;
    if (lat + 1 !== 2) begin bad++; $display("FAIL latency got=%0d required=2", lat + 1); end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (int'(got[k]) !== CASE1[k]) begin
        bad++;
        $display("FAIL unit_impulse Y[%0d] got=%0d required=%0d", k, got[k], CASE1[k]);
      end
    end
    ack();
  endtask

  task automatic test_impulse_scaled();
    impulse(1000, 3);
    total++;
    if (int'(got[0]) !== 500) begin bad++; $display("FAIL scaled_y0 got=%0d required=500", got[0]); end
    total++;
    if (int'(got[15]) !== 5625) begin bad++; $display("FAIL scaled_y15 got=%0d required=5625", got[15]); end
    impulse(-1, 0);
    total++;
    if (int'(got[0]) !== -4) begin bad++; $display("FAIL neg_y0 got=%0d required=-4", got[0]); end
    total++;
    if (int'(got[15]) !== -45) begin bad++; $display("FAIL neg_y15 got=%0d required=-45", got[15]); end
  endtask

  task automatic test_overflow();
    int e0;
    int e15;
`ifdef DST7_SEQ_SAT_EN
    e0 = 32767;
    e15 = 32767;
`else
    e0 = -4;
    e15 = 32723;
`endif
    impulse(32767, 0);
    total++;
    if (int'(got[0]) !== e0) begin bad++; $display("FAIL ovf_y0 got=%0d required=%0d", got[0], e0); end
    total++;
    if (int'(got[15]) !== e15) begin bad++; $display("FAIL ovf_y15 got=%0d required=%0d", got[15], e15); end
  endtask

  task automatic test_gaps();
    int lat;
    int ref_y [16];
    logic [255:0] snap;
    for (int n = 0; n < 16; n++) mx[n] = int'($urandom_range(0, 8000)) - 4000;
    run_model(4);
    run_block(4, 1'b0);
    wait_out(lat);
    ack();
    for (int k = 0; k < 16; k++) begin
      ref_y[k] = int'(got[k]);
      total++;
      if (ref_y[k] !== exp_y[k]) begin
        bad++;
        $display("FAIL gapless_model Y[%0d] got=%0d required=%0d", k, ref_y[k], exp_y[k]);
      end
    end
    run_block(4, 1'b1);
    wait_out(lat);
    snap = out_data;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (out_data !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL hold_cycle%0d data=%h required=%h in_ready=%b required=0 out_valid=%b required=1",
                 c, out_data, snap, in_ready, out_valid);
      end
    end
    ack();
    for (int k = 0; k < 16; k++) begin
      total++;
      if (int'(got[k]) !== ref_y[k]) begin
        bad++;
        $display("FAIL gaps_vs_gapless Y[%0d] got=%0d required=%0d", k, got[k], ref_y[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    cfg_shift = 5'd2;
    for (int n = 0; n < 7; n++) send(int'($urandom_range(1, 3000)), 1'b0);
    rst_n = 1'b0;
    repeat (2) step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_out_valid got=%b required=0", out_valid); end
    rst_n = 1'b1;
    step();
    for (int n = 0; n < 16; n++) mx[n] = 0;
    mx[0] = 1;
    run_block(0, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_early_valid got=%b required=0", out_valid); end
    wait_out(lat);
    ack();
    for (int k = 0; k < 16; k++) begin
      total++;
      if (int'(got[k]) !== CASE1[k]) begin
        bad++;
        $display("FAIL midreset_impulse Y[%0d] got=%0d required=%0d", k, got[k], CASE1[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int xs [3][16];
    int shs [3];
    int ocyc [3];
    int b;
    int i;
    int nout;
    int cyc;
    shs = '{0, 4, 7};
    for (int j = 0; j < 3; j++)
      for (int n = 0; n < 16; n++) xs[j][n] = int'($urandom_range(0, 20000)) - 10000;
    b = 0; i = 0; nout = 0; cyc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    while (nout < 3 && cyc < 300) begin
      bit rdy;
      if (b < 3) begin
        in_data = 16'(xs[b][i]);
        cfg_shift = (i == 0) ? 5'(shs[b]) : 5'd31;
      end else begin
        in_valid = 1'b0;
      end
      rdy = in_ready & in_valid;
      if (out_valid) begin
        capture();
        for (int n = 0; n < 16; n++) mx[n] = xs[nout][n];
        run_model(shs[nout]);
        for (int k = 0; k < 16; k++) begin
          total++;
          if (int'(got[k]) !== exp_y[k]) begin
            bad++;
            $display("FAIL b2b_blk%0d Y[%0d] got=%0d required=%0d", nout, k, got[k], exp_y[k]);
          end
        end
        ocyc[nout] = cyc;
        nout++;
      end
      step();
      cyc++;
      if (rdy) begin
        i++;
        if (i == 16) begin
          i = 0;
          b++;
        end
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    total++;
    if (nout !== 3) begin
      bad++;
      $display("FAIL b2b_blocks got=%0d required=3", nout);
    end else begin
      for (int j = 1; j < 3; j++) begin
        total++;
        if (ocyc[j] - ocyc[j-1] !== 19) begin
          bad++;
          $display("FAIL b2b_period%0d got=%0d required=19", j, ocyc[j] - ocyc[j-1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse_unit();
    test_impulse_scaled();
    test_overflow();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
